fetch_sequencer: RTL



---
 rtl/fetch_sequencer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// Fetch/execute sequencer: PC, IR and FETCH/EXEC1/EXEC2/HALT state; optional SEQ_SINGLE_STEP_EN single-step.
// Latency: 2 or 3 cycles per instruction; all outputs registered (halted decodes the state register).
// Backpressure: none; run=0 halts at the next instruction boundary.
module fetch_sequencer #(
  parameter int PC_W = 12
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            run,
  input  logic            step,
  input  logic [15:0]     ram_q,
  input  logic [PC_W-1:0] reg_target,
  input  logic [PC_W-1:0] ret_addr,
  input  logic            sm_extra,
  input  logic            stop,
  input  logic            pc_sload,
  input  logic            pc_cnt_en,
  input  logic [1:0]      jump_sel,
  output logic [1:0]      state,
  output logic [15:0]     instruction,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic [15:0]     retired
);

  typedef enum logic [1:0] {
    S_FETCH = 2'b00,
    S_EXEC1 = 2'b10,
    S_EXEC2 = 2'b01,
    S_HALT  = 2'b11
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_nxt;
  logic [PC_W-1:0] w_jump_tgt;
  logic            w_jump_vld;
  logic [15:0]     r_ir;
  logic [15:0]     r_retired;
  logic            w_done;
  logic            w_ir_load;
  logic            w_step_accept;
  logic            w_step_go;

`ifdef SEQ_SINGLE_STEP_EN
  logic r_step_latch;

  assign w_step_accept = (r_state == S_HALT) && !run && step;
  assign w_step_go     = r_step_latch;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_step_latch <= 1'b0;
    else if (w_step_accept)
      r_step_latch <= 1'b1;
    else if (w_done)
      r_step_latch <= 1'b0;
  end
`else
  logic w_unused_step;

  assign w_unused_step = step;
  assign w_step_accept = 1'b0;
  assign w_step_go     = 1'b0;
`endif

  // Reserved select (11) leaves the PC where it is instead of falling through to increment.
  always_comb begin
    w_jump_tgt = r_pc;
    w_jump_vld = 1'b1;
    case (jump_sel)
      2'b00:   w_jump_tgt = reg_target;
      2'b01:   w_jump_tgt = r_ir[PC_W-1:0];
      2'b10:   w_jump_tgt = ret_addr;
      default: w_jump_vld = 1'b0;
    endcase
  end

  always_comb begin
    w_pc_nxt = r_pc;
    if (r_state != S_HALT && !stop) begin
      if (pc_sload) begin
        if (w_jump_vld)
          w_pc_nxt = w_jump_tgt;
      end else if (pc_cnt_en) begin
        w_pc_nxt = r_pc + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    w_ir_load   = 1'b0;
    case (r_state)
      S_HALT: begin
        if (run || w_step_accept)
          w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        w_ir_load   = 1'b1;
        w_state_nxt = (run || w_step_go) ? S_EXEC1 : S_HALT;
      end
      S_EXEC1: begin
        if (stop) begin
          w_done      = 1'b1;
          w_state_nxt = S_HALT;
        end else if (sm_extra) begin
          w_state_nxt = S_EXEC2;
        end else begin
          w_done      = 1'b1;
          w_state_nxt = w_step_go ? S_HALT : S_FETCH;
        end
      end
      default: begin
        w_done      = 1'b1;
        w_state_nxt = (stop || w_step_go) ? S_HALT : S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_HALT;
      r_pc      <= '0;
      r_ir      <= '0;
      r_retired <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_ir_load)
        r_ir <= ram_q;
      if (w_done)
        r_retired <= r_retired + 16'd1;
    end
  end

  assign state       = r_state;
  assign instruction = r_ir;
  assign pc          = r_pc;
  assign halted      = (r_state == S_HALT);
  assign retired     = r_retired;

endmodule
